addsub_seq_ctrl: RTL and testbench

- Multi-cycle controller that computes a wide add/subtract through one shared 4-bit add/sub slice, one nibble per cycle, LSB nibble first.
- Carry is chained between nibbles.
- Sits between a requester (valid/ready request channel) and a consumer (valid/ready response channel).
- Returns a full-width sum/difference with carry, signed-overflow and zero flags, using the same flag semantics as the team's 4-bit add/sub unit.

---
 rtl/addsub_pkg.sv | 15 +
 rtl/nibble_addsub.sv | 19 +
 rtl/addsub_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_addsub_seq_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller and its slice.
package addsub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_addsub.sv
// Combinational 4-bit add/sub slice; inv and cin are separate so the carry can chain.
module nibble_addsub
  import addsub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             inv,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b ^ {NIB_W{inv}}} + {{NIB_W{1'b0}}, cin};
  assign s     = w_sum[NIB_W-1:0];
  assign cout  = w_sum[NIB_W];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Wide add/subtract computed one nibble per cycle (LSB first) through a shared slice,
// with valid/ready request and response channels.
module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_sub,
  input  logic [NIB_W*NIBBLES-1:0] req_a,
  input  logic [NIB_W*NIBBLES-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [NIB_W*NIBBLES-1:0] rsp_s,
  output logic                   rsp_carry,
  output logic                   rsp_overflow,
  output logic                   rsp_zero,
  output logic                   busy
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_res;
  logic             r_sub;
  logic             r_c;
  logic [KW-1:0]    r_k;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic             r_busy;
  logic [W-1:0]     r_rsp_s;
  logic             r_rsp_carry;
  logic             r_rsp_overflow;
  logic             r_rsp_zero;

  logic [NIB_W-1:0] w_a_nib;
  logic [NIB_W-1:0] w_b_nib;
  logic [NIB_W-1:0] w_sum;
  logic             w_cout;
  logic             w_last;
  logic             w_accept;
  logic             w_ovf;
  logic [W-1:0]     w_res_nxt;

  assign w_last   = (r_k == KW'(NIBBLES - 1));
  assign w_accept = (r_state == IDLE) && req_valid;

  // Select the active nibble and merge the slice sum into the partial result.
  always_comb begin
    w_a_nib   = r_a[NIB_W*int'(r_k) +: NIB_W];
    w_b_nib   = r_b[NIB_W*int'(r_k) +: NIB_W];
    w_res_nxt = r_res;
    w_res_nxt[NIB_W*int'(r_k) +: NIB_W] = w_sum;
  end

  nibble_addsub u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .inv  (r_sub),
    .cin  (r_c),
    .s    (w_sum),
    .cout (w_cout)
  );

  // Signed overflow compares the operand signs after B has been conditionally inverted.
  assign w_ovf = (r_a[W-1] == (r_b[W-1] ^ r_sub)) && (w_sum[NIB_W-1] != r_a[W-1]);

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) w_state_nxt = RUN;
        else           w_state_nxt = IDLE;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
        else        w_state_nxt = RUN;
      end
      DONE: begin
        if (rsp_ready) w_state_nxt = IDLE;
        else           w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with handshake outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  // Operand capture, nibble iteration and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a            <= {W{1'b0}};
      r_b            <= {W{1'b0}};
      r_sub          <= OP_ADD;
      r_c            <= 1'b0;
      r_k            <= {KW{1'b0}};
      r_res          <= {W{1'b0}};
      r_rsp_s        <= {W{1'b0}};
      r_rsp_carry    <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_zero     <= 1'b0;
    end else if (w_accept) begin
      r_a   <= req_a;
      r_b   <= req_b;
      r_sub <= req_sub;
      r_c   <= (req_sub == OP_SUB);
      r_k   <= {KW{1'b0}};
      r_res <= {W{1'b0}};
    end else if (r_state == RUN) begin
      r_res <= w_res_nxt;
      r_c   <= w_cout;
      if (w_last) begin
        r_k            <= r_k;
        r_rsp_s        <= w_res_nxt;
        r_rsp_carry    <= w_cout;
        r_rsp_overflow <= w_ovf;
        r_rsp_zero     <= ~|w_res_nxt;
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign busy         = r_busy;
  assign rsp_s        = r_rsp_s;
  assign rsp_carry    = r_rsp_carry;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_zero     = r_rsp_zero;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl: directed cases plus random operations
// checked against an arithmetic reference model.
module tb_addsub_seq_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_sub;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_s;
  logic         rsp_carry;
  logic         rsp_overflow;
  logic         rsp_zero;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  addsub_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sub      (req_sub),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_s        (rsp_s),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, overflow, zero, s} from plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    longint ua, ub, u, sa, sb, sr, smax, smin;
    logic [W-1:0] s;
    logic c, v;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = (a[W-1]) ? ua - (longint'(1) <<< W) : ua;
    sb   = (b[W-1]) ? ub - (longint'(1) <<< W) : ub;
    smax = (longint'(1) <<< (W-1)) - 1;
    smin = -(longint'(1) <<< (W-1));
    if (sub) begin
      u  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      u  = ua + ub;
      c  = (u >= (longint'(1) <<< W));
      sr = sa + sb;
    end
    s = W'(u);
    v = (sr > smax) || (sr < smin);
    return {c, v, (s == '0), s};
  endfunction

  // One operation; starts and ends just after a falling edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int hold, input bit scramble, input bit chain,
                        input logic [W-1:0] na, input logic [W-1:0] nb, input logic nsub);
    logic [W+2:0] exp;
    int n;
    exp = model(a, b, sub);
    req_a = a; req_b = b; req_sub = sub; req_valid = 1'b1;
    rsp_ready = (hold == 0);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (scramble) begin
        req_a = W'($urandom); req_b = W'($urandom); req_sub = 1'($urandom);
      end
    end
    chk("latency", 32'(n), 32'(NIBBLES));
    chk("rsp_s", 32'(rsp_s), 32'(exp[W-1:0]));
    chk("carry", 32'(rsp_carry), 32'(exp[W+2]));
    chk("overflow", 32'(rsp_overflow), 32'(exp[W+1]));
    chk("zero", 32'(rsp_zero), 32'(exp[W]));
    chk("busy_done", 32'(busy), 32'd1);
    if (chain) begin
      req_a = na; req_b = nb; req_sub = nsub; req_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_s", 32'(rsp_s), 32'(exp[W-1:0]));
      chk("hold_flags", {29'd0, rsp_carry, rsp_overflow, rsp_zero}, {29'd0, exp[W+2:W]});
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("pulse_end", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_hold_s", 32'(rsp_s), 32'(exp[W-1:0]));
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; req_valid = 1'b0; req_sub = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_s", 32'(rsp_s), 32'd0);
    chk("rst_flags", {29'd0, rsp_carry, rsp_overflow, rsp_zero}, 32'd0);

    run_op(16'h1234, 16'h0FFF, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Backpressure with a second request waiting behind the response.
    run_op(16'hA5A5, 16'h1111, 1'b1, 3, 1'b0, 1'b1, 16'h4321, 16'h1234, 1'b0);
    run_op(16'h4321, 16'h1234, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b1, 1'b0, '0, '0, 1'b0);

    // Reset after two nibbles of an add.
    req_a = 16'h1111; req_b = 16'h2222; req_sub = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    run_op(16'h0010, 16'h0001, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
             1'b1, 1'b0, '0, '0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
